// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for the M extension (DIV/DIVU/REM/REMU and W forms).
// One operation in flight; issue is back-pressured through div_ready_o.
module iter_divider #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter bit IS_XLEN64     = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic                     div_valid_i,
  input  logic [7:0]               operation_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  output logic                     div_ready_o,
  output logic                     div_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] div_trans_id_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};

  // Extend a 32-bit value to XLEN, sign- or zero-filling the upper bits.
  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r       = {XLEN{sgn & v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [XLEN-1:0]          rem_q, rem_d;
  logic [XLEN-1:0]          quo_q, quo_d;
  logic [XLEN-1:0]          dvs_q, dvs_d;
  logic                     neg_quo_q, neg_quo_d;
  logic                     neg_rem_q, neg_rem_d;
  logic                     is_rem_q, is_rem_d;
  logic                     is_word_q, is_word_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic [TRANS_ID_BITS-1:0] tag_q, tag_d;
  logic                     valid_q, valid_d;
  logic                     ready_q, ready_d;

  logic                     legal_s, accept_s;
  logic                     op_signed_s, op_word_s, op_rem_s;
  logic [XLEN-1:0]          a_ext_s, b_ext_s, min_s;
  logic                     neg_a_s, neg_b_s;
  logic [XLEN-1:0]          mag_a_s, mag_b_s, quo_init_s;
  logic                     div_zero_s, ovf_s;
  logic [XLEN-1:0]          spec_raw_s, spec_res_s;
  logic [XLEN:0]            rem_shift_s, diff_s;
  logic                     ge_s;
  logic [CW-1:0]            last_s;
  logic [XLEN-1:0]          q_fix_s, r_fix_s, fin_raw_s, fin_res_s;

  // Opcode decode and operand preparation for the accept cycle.
  always_comb begin
    legal_s     = div_valid_i & (operation_i[7:3] == 5'b01011);
    accept_s    = legal_s & (state_q == S_IDLE) & ~flush_i;
    op_signed_s = ~operation_i[0];
    op_word_s   = IS_XLEN64 & operation_i[1];
    op_rem_s    = operation_i[2];

    if (op_word_s) begin
      a_ext_s = ext32(operand_a_i[31:0], op_signed_s);
      b_ext_s = ext32(operand_b_i[31:0], op_signed_s);
      min_s   = ext32(32'h8000_0000, 1'b1);
    end else begin
      a_ext_s = operand_a_i;
      b_ext_s = operand_b_i;
      min_s   = MIN_FULL;
    end

    neg_a_s    = op_signed_s & a_ext_s[XLEN-1];
    neg_b_s    = op_signed_s & b_ext_s[XLEN-1];
    mag_a_s    = neg_a_s ? negate(a_ext_s) : a_ext_s;
    mag_b_s    = neg_b_s ? negate(b_ext_s) : b_ext_s;
    // Word dividends sit in the top 32 bits so 32 shifts move them all into rem.
    quo_init_s = op_word_s ? (mag_a_s << (XLEN - 32)) : mag_a_s;

    div_zero_s = (b_ext_s == ZERO);
    ovf_s      = op_signed_s & (a_ext_s == min_s) & (b_ext_s == ALL_ONE);

    if (div_zero_s) begin
      spec_raw_s = op_rem_s ? a_ext_s : ALL_ONE;
    end else begin
      spec_raw_s = op_rem_s ? ZERO : a_ext_s;
    end
    spec_res_s = op_word_s ? ext32(spec_raw_s[31:0], 1'b1) : spec_raw_s;
  end

  // One restoring step plus final sign fixup and result selection.
  always_comb begin
    rem_shift_s = {rem_q, quo_q[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_q};
    ge_s        = ~diff_s[XLEN];
    last_s      = is_word_q ? CW'(31) : CW'(XLEN - 1);

    q_fix_s   = neg_quo_q ? negate(quo_q) : quo_q;
    r_fix_s   = neg_rem_q ? negate(rem_q) : rem_q;
    fin_raw_s = is_rem_q ? r_fix_s : q_fix_s;
    fin_res_s = is_word_q ? ext32(fin_raw_s[31:0], 1'b1) : fin_raw_s;
  end

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    is_word_d = is_word_q;
    result_d  = result_q;
    tag_d     = tag_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          tag_d     = trans_id_i;
          is_rem_d  = op_rem_s;
          is_word_d = op_word_s;
          if (div_zero_s | ovf_s) begin
            result_d = spec_res_s;
            state_d  = S_DONE;
          end else begin
            rem_d     = ZERO;
            quo_d     = quo_init_s;
            dvs_d     = mag_b_s;
            neg_quo_d = neg_a_s ^ neg_b_s;
            neg_rem_d = neg_a_s;
            count_d   = '0;
            state_d   = S_DIVIDE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIVIDE: begin
        rem_d = ge_s ? diff_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ge_s};
        if (count_q == last_s) begin
          state_d = S_FINISH;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      S_FINISH: begin
        result_d = fin_res_s;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end

    valid_d = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= ZERO;
      quo_q     <= ZERO;
      dvs_q     <= ZERO;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      is_word_q <= 1'b0;
      result_q  <= ZERO;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      is_word_q <= is_word_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign div_ready_o    = ready_q;
  assign div_valid_o    = valid_q;
  assign result_o       = result_q;
  assign div_trans_id_o = tag_q;

endmodule
